// File: rtl/sync_ptr_gen.sv
// Destination-side Gray pointer synchroniser with binary decode, advance pulse and advance amount.
// Define SYNC_PTR_CHK_EN to build the sticky illegal-Gray-transition checker (chk_err); otherwise chk_err is 0.
module sync_ptr_gen #(
    parameter int ASIZE  = 4,
    parameter int STAGES = 2
) (
    input  logic             sync_clk,
    input  logic             sync_rst,
    input  logic [ASIZE:0]   ptr,
    input  logic             err_clr,
    output logic [ASIZE:0]   sync_ptr,
    output logic [ASIZE:0]   sync_bin,
    output logic             ptr_adv,
    output logic [ASIZE:0]   adv_cnt,
    output logic             chk_err
);

    localparam int W = ASIZE + 1;

    generate
        if ((STAGES < 2) || (STAGES > 4)) begin : g_bad_stages
            $error("sync_ptr_gen: STAGES must be in the range 2..4");
        end
    endgenerate

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [W-1:0] v);
        return (v & (v - {{(W-1){1'b0}}, 1'b1})) != {W{1'b0}};
    endfunction

    logic [W-1:0] stage_r [STAGES];
    logic [W-1:0] g2b_s;
    logic [W-1:0] sync_bin_r;
    logic [W-1:0] adv_cnt_r;
    logic         ptr_adv_r;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge sync_clk) begin
        if (!sync_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {W{1'b0}};
            end
        end else begin
            stage_r[0] <= ptr;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign sync_ptr = stage_r[STAGES-1];

    // Gray-to-binary of the settled pointer.
    always_comb begin
        g2b_s = gray2bin(sync_ptr);
    end

    // Decode register; the modular difference makes a wrap from all-ones to zero an advance of one.
    always_ff @(posedge sync_clk) begin
        if (!sync_rst) begin
            sync_bin_r <= {W{1'b0}};
            adv_cnt_r  <= {W{1'b0}};
            ptr_adv_r  <= 1'b0;
        end else begin
            sync_bin_r <= g2b_s;
            adv_cnt_r  <= g2b_s - sync_bin_r;
            ptr_adv_r  <= (g2b_s != sync_bin_r);
        end
    end

    assign sync_bin = sync_bin_r;
    assign adv_cnt  = adv_cnt_r;
    assign ptr_adv  = ptr_adv_r;

`ifdef SYNC_PTR_CHK_EN
    logic [W-1:0] diff_s;
    logic         illegal_s;
    logic         chk_err_r;

    // bin2gray(sync_bin) is the previous synchronised pointer, so diff_s holds the bits that just flipped.
    always_comb begin
        diff_s    = sync_ptr ^ bin2gray(sync_bin_r);
        illegal_s = multi_hot(diff_s);
    end

    // Sticky error flag; a new error on the clearing edge keeps it set.
    always_ff @(posedge sync_clk) begin
        if (!sync_rst) begin
            chk_err_r <= 1'b0;
        end else if (illegal_s) begin
            chk_err_r <= 1'b1;
        end else if (err_clr) begin
            chk_err_r <= 1'b0;
        end else begin
            chk_err_r <= chk_err_r;
        end
    end

    assign chk_err = chk_err_r;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = err_clr;
    assign chk_err          = 1'b0;
`endif

endmodule
